// File: rtl/record_timer.sv
// Elapsed-seconds timer: start/pause/stop commands drive a prescaled seconds
// count presented as binary and as two BCD digits, saturating at MAX_SEC.
module record_timer #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int MAX_SEC  = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_stop,
    output logic [6:0] o_sec,
    output logic [3:0] o_ten,
    output logic [3:0] o_one,
    output logic       o_tick,
    output logic       o_running,
    output logic       o_done
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_TC   = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [6:0]    SEC_MAX    = 7'(MAX_SEC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_s;
    logic [6:0]    sec_r;
    logic [6:0]    sec_s;
    logic [6:0]    sec_inc_s;
    logic [3:0]    ten_r;
    logic [3:0]    ten_s;
    logic [3:0]    one_r;
    logic [3:0]    one_s;
    logic          tick_r;
    logic          tick_s;
    logic          running_r;
    logic          done_r;
    logic          tc_s;

    // Digits count on their own so the display path never needs a divider.
    function automatic logic [7:0] bcd_inc(input logic [3:0] ten, input logic [3:0] one);
        logic [7:0] res;
        if (one == 4'd9) begin
            res = {ten + 4'd1, 4'd0};
        end else begin
            res = {ten, one + 4'd1};
        end
        return res;
    endfunction

    assign tc_s      = (presc_r == PRESC_TC);
    assign sec_inc_s = sec_r + 7'd1;

    // State and datapath registers; running/done are registered from next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            presc_r   <= PRESC_ZERO;
            sec_r     <= 7'd0;
            ten_r     <= 4'd0;
            one_r     <= 4'd0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            presc_r   <= presc_s;
            sec_r     <= sec_s;
            ten_r     <= ten_s;
            one_r     <= one_s;
            tick_r    <= tick_s;
            running_r <= (state_s == ST_RUN);
            done_r    <= (state_s == ST_DONE);
        end
    end

    // Next state: stop beats start beats pause; reaching the limit beats pause.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_stop) begin
                    state_s = ST_IDLE;
                end else if (i_start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_stop) begin
                    state_s = ST_IDLE;
                end else if (tc_s && (sec_inc_s == SEC_MAX)) begin
                    state_s = ST_DONE;
                end else if (i_start) begin
                    state_s = ST_RUN;
                end else if (i_pause) begin
                    state_s = ST_PAUSE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE, ST_DONE: begin
                if (i_stop) begin
                    state_s = ST_IDLE;
                end else if (i_start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: prescaler, seconds, BCD digits and the tick pulse.
    always_comb begin
        presc_s = presc_r;
        sec_s   = sec_r;
        ten_s   = ten_r;
        one_s   = one_r;
        tick_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (i_stop) begin
                    presc_s = PRESC_ZERO;
                    sec_s   = 7'd0;
                    ten_s   = 4'd0;
                    one_s   = 4'd0;
                end else if (tc_s) begin
                    presc_s        = PRESC_ZERO;
                    sec_s          = sec_inc_s;
                    {ten_s, one_s} = bcd_inc(ten_r, one_r);
                    tick_s         = 1'b1;
                end else if (i_pause && !i_start) begin
                    presc_s = presc_r;
                end else begin
                    presc_s = presc_r + PRESC_ONE;
                end
            end
            ST_PAUSE: begin
                if (i_stop) begin
                    presc_s = PRESC_ZERO;
                    sec_s   = 7'd0;
                    ten_s   = 4'd0;
                    one_s   = 4'd0;
                end else begin
                    presc_s = presc_r;
                end
            end
            ST_DONE: begin
                if (i_stop || i_start) begin
                    presc_s = PRESC_ZERO;
                    sec_s   = 7'd0;
                    ten_s   = 4'd0;
                    one_s   = 4'd0;
                end else begin
                    presc_s = PRESC_ZERO;
                end
            end
            default: begin
                presc_s = PRESC_ZERO;
                sec_s   = 7'd0;
                ten_s   = 4'd0;
                one_s   = 4'd0;
            end
        endcase
    end

    assign o_sec     = sec_r;
    assign o_ten     = ten_r;
    assign o_one     = one_r;
    assign o_tick    = tick_r;
    assign o_running = running_r;
    assign o_done    = done_r;

endmodule

// File: tb/tb_record_timer.sv
// Self-checking bench for record_timer; the reference model tracks session
// progress in clock cycles and derives seconds and digits arithmetically.
module tb_record_timer;

    localparam int CF = 10;
    localparam int MS = 12;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic       stop;
    logic [6:0] sec;
    logic [3:0] ten;
    logic [3:0] one;
    logic       tick;
    logic       running;
    logic       done;
    logic [17:0] obs;

    int n_cmp = 0;
    int n_err = 0;
    int m_mode = M_IDLE;
    int m_p = 0;
    bit m_tick = 1'b0;

    record_timer #(.CLK_FREQ(CF), .MAX_SEC(MS)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .o_sec(sec), .o_ten(ten), .o_one(one), .o_tick(tick),
        .o_running(running), .o_done(done)
    );

    always #5 clk = ~clk;

    assign obs = {sec, ten, one, tick, running, done};

    // Reference: m_p counts run cycles of the session; a second passes every CF of them.
    function automatic void model_step(input bit r, input bit s, input bit pa, input bit st);
        m_tick = 1'b0;
        if (r) begin
            m_mode = M_IDLE;
            m_p    = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_p = 0;
                    if (!st && s) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (st) begin
                        m_mode = M_IDLE;
                        m_p    = 0;
                    end else if (pa && !s && (m_p % CF) != CF - 1) begin
                        m_mode = M_PAUSE;
                    end else begin
                        m_p    = m_p + 1;
                        m_tick = ((m_p % CF) == 0);
                        if (m_tick && (m_p / CF) == MS) m_mode = M_DONE;
                        else if (pa && !s) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: begin
                    if (st) begin
                        m_mode = M_IDLE;
                        m_p    = 0;
                    end else if (s) begin
                        m_mode = M_RUN;
                    end
                end
                M_DONE: begin
                    if (st) begin
                        m_mode = M_IDLE;
                        m_p    = 0;
                    end else if (s) begin
                        m_mode = M_RUN;
                        m_p    = 0;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endfunction

    function automatic logic [17:0] exp_vec();
        int s;
        s = m_p / CF;
        return {7'(s), 4'(s / 10), 4'(s % 10), m_tick, (m_mode == M_RUN), (m_mode == M_DONE)};
    endfunction

    task automatic cyc(input bit r, input bit s, input bit pa, input bit st);
        rst = r; start = s; pause = pa; stop = st;
        @(posedge clk);
        model_step(r, s, pa, st);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== 18'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected %h", obs, 18'd0);
        end
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, (i % 7) == 3, 1'b0);
            n_cmp++;
            if (obs !== 18'd0) begin
                n_err++; $display("FAIL idle_outputs: cycle %0d got %h expected %h", i, obs, 18'd0);
            end
        end
    endtask

    task automatic test_count_bcd();
        int ticks = 0;
        int first = -1;
        int last = -1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++; $display("FAIL start_latency: running got %b expected 1", running);
        end
        for (int i = 1; i <= 110; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (tick === 1'b1) begin
                ticks++;
                if (first < 0) begin
                    first = i;
                end else begin
                    n_cmp++;
                    if (i - last !== 10) begin
                        n_err++; $display("FAIL tick_spacing: got %0d expected 10", i - last);
                    end
                end
                last = i;
            end
        end
        n_cmp++;
        if (ticks !== 11) begin
            n_err++; $display("FAIL tick_count: got %0d expected 11", ticks);
        end
        n_cmp++;
        if (first !== 10) begin
            n_err++; $display("FAIL first_tick: got %0d expected 10", first);
        end
        n_cmp++;
        if ({sec, ten, one} !== {7'd11, 4'd1, 4'd1}) begin
            n_err++; $display("FAIL bcd_carry: got sec=%0d ten=%0d one=%0d expected 11/1/1", sec, ten, one);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_pause_resume();
        int n = -1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (sec !== 7'd1) begin
            n_err++; $display("FAIL pre_pause_sec: got %0d expected 1", sec);
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if ({sec, tick, running} !== {7'd1, 1'b0, 1'b0}) begin
                n_err++; $display("FAIL paused_hold: got sec=%0d tick=%b run=%b expected 1/0/0", sec, tick, running);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (tick === 1'b1 && n < 0) n = i;
        end
        n_cmp++;
        if (n !== 5) begin
            n_err++; $display("FAIL resume_partial: tick after %0d cycles expected 5", n);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_p != MS * CF - 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== exp_vec() || done !== 1'b0) begin
            n_err++; $display("FAIL pre_limit: got %h expected %h", obs, exp_vec());
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (obs !== {7'd12, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL done_entry: got %h expected %h", obs, {7'd12, 4'd1, 4'd2, 1'b1, 1'b0, 1'b1});
        end
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0, $urandom_range(0, 3) == 0, 1'b0);
            n_cmp++;
            if ({sec, tick, done} !== {7'd12, 1'b0, 1'b1}) begin
                n_err++; $display("FAIL done_hold: got sec=%0d tick=%b done=%b expected 12/0/1", sec, tick, done);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({sec, running, done} !== {7'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL done_restart: got sec=%0d run=%b done=%b expected 0/1/0", sec, running, done);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_priority();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if ({sec, running, done} !== {7'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL stop_over_start: got sec=%0d run=%b expected 0/0", sec, running);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({sec, tick, running} !== {7'd1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL tc_with_pause: got sec=%0d tick=%b run=%b expected 1/1/0", sec, tick, running);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({sec, tick, running} !== {7'd1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL after_tc_pause: got sec=%0d tick=%b run=%b expected 1/0/0", sec, tick, running);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (obs !== 18'd0) begin
            n_err++; $display("FAIL tc_with_stop: got %h expected %h", obs, 18'd0);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 75; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({sec, running} !== {7'd7, 1'b0}) begin
            n_err++; $display("FAIL paused_at_7: got sec=%0d run=%b expected 7/0", sec, running);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== 18'd0) begin
            n_err++; $display("FAIL reset_in_pause: got %h expected %h", obs, 18'd0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({sec, tick, running} !== {7'd1, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL count_after_reset: got sec=%0d tick=%b run=%b expected 1/1/1", sec, tick, running);
        end
    endtask

    task automatic test_random();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 255) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random_model: cycle %0d got %h expected %h", i, obs, exp_vec());
            end
            n_cmp++;
            if (int'(ten) * 10 + int'(one) !== int'(sec)) begin
                n_err++; $display("FAIL bcd_invariant: got ten=%0d one=%0d for sec=%0d", ten, one, sec);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        test_reset();
        test_count_bcd();
        test_pause_resume();
        test_saturation();
        test_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/record_timer.md
# record_timer

Elapsed-time counter for the recorder/player datapath. It turns start/pause/stop commands from the top-level controller into a seconds count, using a prescaled system clock. It presents the count as binary and as two BCD digits, which feed the seven-segment decoder stage directly. It also saturates at a configurable limit and flags completion so the controller can end a record or play session.

## Interface
- CLK_FREQ, 50_000_000: clock cycles per second; prescaler terminal count is CLK_FREQ-1.
- MAX_SEC, 32: saturation limit in seconds, legal range 1..99.
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  one clock; reset is synchronous and active-high.
- i_start  input  1  level-sampled command: start from IDLE/DONE, resume from PAUSE.
- i_pause  input  1  level-sampled command: freeze count while RUN.
- i_stop  input  1  level-sampled command: return to IDLE and clear.
- o_sec  output  7  elapsed seconds, binary, 0..MAX_SEC.
- o_ten  output  4  tens digit of o_sec, BCD 0..9.
- o_one  output  4  ones digit of o_sec, BCD 0..9.
- o_tick  output  1  one-cycle pulse, high in the cycle o_sec first shows a new value.
- o_running  output  1  high while state is RUN.
- o_done  output  1  high while state is DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Command priority each cycle: i_stop > i_start > i_pause.
- IDLE: prescaler = 0, o_sec/o_ten/o_one = 0. i_start goes to RUN. i_pause is ignored.
- RUN: the prescaler increments every cycle.
  - At prescaler == CLK_FREQ-1: prescaler goes to 0, o_sec increments, BCD digits increment, o_tick pulses.
  - If the new o_sec == MAX_SEC, the next state is DONE.
  - i_pause goes to PAUSE with the prescaler value held.
  - i_stop goes to IDLE and clears everything.
  - i_start has no effect.
- PAUSE: prescaler and count are held. i_start returns to RUN and resumes from the held prescaler value, so partial seconds are kept. i_stop goes to IDLE.
- DONE: o_sec = MAX_SEC, digits hold, prescaler = 0, o_done = 1.
  - i_start clears the count and goes to RUN, starting a new session from 0.
  - i_stop goes to IDLE.
  - i_pause is ignored.
- BCD digits are kept as their own counters, with no divide or modulo.
  - o_one wraps 9 to 0 and increments o_ten in the same cycle.
  - Invariant: o_ten*10 + o_one == o_sec at all times.
- Simultaneous terminal count and i_pause in RUN: the second is counted (o_sec increments, o_tick pulses), prescaler goes to 0, next state is PAUSE.
- Simultaneous terminal count and i_stop: i_stop wins. The count clears, there is no o_tick, next state is IDLE.
- Terminal count that reaches MAX_SEC together with i_pause: DONE wins over PAUSE.
- Prescaler width is $clog2(CLK_FREQ). The comparison is exact equality, and the prescaler never exceeds CLK_FREQ-1.

## Timing
- Reset: when i_rst is sampled high, the next state is IDLE and all outputs are 0 after that edge. Reset mid-RUN or mid-PAUSE discards all progress.
- All outputs are registered; no combinational path from input to output.
- Start latency: i_start sampled at edge k gives o_running = 1 after edge k; the first prescaler increment happens at edge k+1.
- The first o_sec increment is visible after edge k+CLK_FREQ, and o_tick is high for that single cycle.
- Uninterrupted RUN: o_sec increments exactly every CLK_FREQ cycles.
- Pause: i_pause sampled at edge p gives o_running = 0 after edge p; the prescaler value at p is retained.
- DONE entry: o_done = 1 in the same cycle o_sec shows MAX_SEC and o_tick pulses.
- Commands are levels. Holding i_start in RUN is harmless. Holding i_start in DONE restarts every cycle in which the state is DONE.

## Test plan
- Reset and idle: CLK_FREQ=10, MAX_SEC=12; assert i_rst 3 cycles, then release and idle 50 cycles -> all outputs 0, o_done 0, no o_tick.
- Count and BCD carry: pulse i_start, run 110 cycles.
  - o_sec = 11, o_ten = 1, o_one = 1.
  - o_tick pulses 11 times, spaced 10 cycles apart.
  - First tick appears 10 cycles after the cycle in which o_running rose.
- Pause/resume keeps partial second: start, run 15 cycles (o_sec=1, prescaler=5), pause for 40 cycles, resume.
  - o_sec stays 1 during the pause.
  - Next tick comes 5 cycles after resume, not 10.
- Saturation: run to MAX_SEC=12 -> o_sec = 12, o_done = 1, o_running = 0; after 100 more cycles the count is unchanged and there are no ticks. A following i_start gives o_sec = 0 and RUN.
- Priority collisions: i_stop and i_start together in RUN -> IDLE, o_sec = 0. i_pause asserted in the terminal-count cycle -> o_sec increments, o_tick pulses, state becomes PAUSE.
- Reset mid-operation: i_rst in PAUSE with o_sec=7 -> all outputs 0 after the next edge. i_start then counts from 0.
